// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, sequence codes and helpers for seq_monitor
package seq_pkg;

  typedef logic [2:0] code_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam code_t SEQ0 = 3'd0;
  localparam code_t SEQ1 = 3'd3;
  localparam code_t SEQ2 = 3'd5;
  localparam code_t SEQ3 = 3'd4;
  localparam code_t SEQ4 = 3'd7;
  localparam code_t SEQ5 = 3'd2;

  function automatic code_t next_code(input code_t c);
    case (c)
      SEQ0:    next_code = SEQ1;
      SEQ1:    next_code = SEQ2;
      SEQ2:    next_code = SEQ3;
      SEQ3:    next_code = SEQ4;
      SEQ4:    next_code = SEQ5;
      default: next_code = SEQ0;
    endcase
  endfunction

  // Illegal codes map to 0; callers qualify with the legal flag.
  function automatic logic [2:0] code_to_step(input code_t c);
    case (c)
      SEQ1:    code_to_step = 3'd1;
      SEQ2:    code_to_step = 3'd2;
      SEQ3:    code_to_step = 3'd3;
      SEQ4:    code_to_step = 3'd4;
      SEQ5:    code_to_step = 3'd5;
      default: code_to_step = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational decode of a counter code into legal/step/next
module seq_decode
  import seq_pkg::*;
(
  input  code_t      code,
  output logic       legal,
  output logic [2:0] idx,
  output code_t      nxt
);

  assign legal = (code != 3'd1) && (code != 3'd6);
  assign idx   = code_to_step(code);
  assign nxt   = next_code(code);

endmodule

// File: rtl/seq_monitor.sv
// rtl/seq_monitor.sv - lock/step/error monitor for the custom-sequence counter; option SEQ_MONITOR_STICKY_ERR_EN
module seq_monitor
  import seq_pkg::*;
#(
  parameter int LOCK_LEN = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [2:0]       q_in,
  output logic [2:0]       step,
  output logic             step_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             wrap,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef SEQ_MONITOR_STICKY_ERR_EN
  ,
  output logic             err_sticky
`endif
);

  localparam logic [2:0] LOCK_N = 3'(LOCK_LEN);

  state_t     state, state_n;
  logic [2:0] run, run_n;
  code_t      exp_code, exp_n;
  logic [2:0] step_n;
  logic       err_n, wrap_n, err_inc, cyc_inc;
  logic       legal;
  logic [2:0] idx;
  code_t      nxt;

  seq_decode u_decode (
    .code  (q_in),
    .legal (legal),
    .idx   (idx),
    .nxt   (nxt)
  );

  always_comb begin
    state_n = state;
    run_n   = run;
    exp_n   = exp_code;
    step_n  = step;
    err_n   = 1'b0;
    wrap_n  = 1'b0;
    err_inc = 1'b0;
    cyc_inc = 1'b0;
    if (sample_en) begin
      case (state)
        HUNT: begin
          if (legal) begin
            exp_n = nxt;
            run_n = 3'd1;
            if (LOCK_N == 3'd1) begin
              state_n = LOCKED;
              step_n  = idx;
            end else begin
              state_n = ACQ;
            end
          end
        end
        ACQ: begin
          if (legal && q_in == exp_code) begin
            run_n = run + 3'd1;
            exp_n = nxt;
            if (run + 3'd1 == LOCK_N) begin
              state_n = LOCKED;
              step_n  = idx;
            end
          end else if (legal) begin
            run_n = 3'd1;
            exp_n = nxt;
          end else begin
            state_n = HUNT;
          end
        end
        LOCKED: begin
          // exp_code is always a legal code, so a match implies legal
          if (q_in == exp_code) begin
            step_n = idx;
            exp_n  = nxt;
            if (q_in == SEQ0) begin
              wrap_n  = 1'b1;
              cyc_inc = 1'b1;
            end
          end else begin
            err_n   = 1'b1;
            err_inc = 1'b1;
            if (legal) begin
              state_n = ACQ;
              run_n   = 3'd1;
              exp_n   = nxt;
            end else begin
              state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= HUNT;
      run       <= 3'd0;
      exp_code  <= SEQ0;
      step      <= 3'd0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
      cycle_cnt <= '0;
    end else begin
      state    <= state_n;
      run      <= run_n;
      exp_code <= exp_n;
      step     <= step_n;
      err      <= err_n;
      wrap     <= wrap_n;
      if (err_inc && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (cyc_inc && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

`ifdef SEQ_MONITOR_STICKY_ERR_EN
  always_ff @(posedge clk) begin
    if (clear) err_sticky <= 1'b0;
    else if (sample_en && (err_n || !legal)) err_sticky <= 1'b1;
  end
`endif

  assign locked     = (state == LOCKED);
  assign step_valid = locked;

endmodule

// File: tb/tb_seq_monitor.sv
// tb/tb_seq_monitor.sv - self-checking bench for seq_monitor (two counter widths, optional SEQ_MONITOR_STICKY_ERR_EN)
module tb_seq_monitor;

  localparam int LOCK_LEN = 3;

  logic       clk = 1'b0;
  logic       clear;
  logic       sample_en;
  logic [2:0] q_in;

  logic [2:0] a_step, b_step;
  logic       a_step_valid, b_step_valid, a_locked, b_locked;
  logic       a_err, b_err, a_wrap, b_wrap;
  logic [7:0] a_err_cnt, a_cycle_cnt;
  logic [1:0] b_err_cnt, b_cycle_cnt;
`ifdef SEQ_MONITOR_STICKY_ERR_EN
  logic       a_sticky, b_sticky;
`endif

  seq_monitor #(.LOCK_LEN(LOCK_LEN), .CNT_W(8)) dut (
    .clk(clk), .clear(clear), .sample_en(sample_en), .q_in(q_in),
    .step(a_step), .step_valid(a_step_valid), .locked(a_locked),
    .err(a_err), .err_cnt(a_err_cnt), .wrap(a_wrap), .cycle_cnt(a_cycle_cnt)
`ifdef SEQ_MONITOR_STICKY_ERR_EN
    , .err_sticky(a_sticky)
`endif
  );

  seq_monitor #(.LOCK_LEN(LOCK_LEN), .CNT_W(2)) dut_s (
    .clk(clk), .clear(clear), .sample_en(sample_en), .q_in(q_in),
    .step(b_step), .step_valid(b_step_valid), .locked(b_locked),
    .err(b_err), .err_cnt(b_err_cnt), .wrap(b_wrap), .cycle_cnt(b_cycle_cnt)
`ifdef SEQ_MONITOR_STICKY_ERR_EN
    , .err_sticky(b_sticky)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: position in the 6-long sequence, mode 0=hunting 1=acquiring 2=locked
  int seq_codes[6] = '{0, 3, 5, 4, 7, 2};
  int m_mode, m_run, m_exp, m_step, m_errs, m_cycles;
  bit m_err, m_wrap, m_sticky;

  function automatic int find_idx(input int c);
    for (int i = 0; i < 6; i++) if (seq_codes[i] == c) return i;
    return -1;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    int i;
    m_err  = 0;
    m_wrap = 0;
    if (clear) begin
      m_mode = 0; m_run = 0; m_exp = 0; m_step = 0;
      m_errs = 0; m_cycles = 0; m_sticky = 0;
    end else if (sample_en) begin
      i = find_idx(int'(q_in));
      if (i < 0) m_sticky = 1;
      if (m_mode == 2) begin
        if (int'(q_in) == m_exp) begin
          m_step = i;
          m_exp  = seq_codes[(i + 1) % 6];
          if (i == 0) begin m_wrap = 1; m_cycles++; end
        end else begin
          m_err = 1; m_errs++; m_sticky = 1;
          if (i >= 0) begin m_mode = 1; m_run = 1; m_exp = seq_codes[(i + 1) % 6]; end
          else m_mode = 0;
        end
      end else if (i < 0) begin
        m_mode = 0;
      end else begin
        if (m_mode == 1 && int'(q_in) == m_exp) m_run++;
        else m_run = 1;
        m_exp = seq_codes[(i + 1) % 6];
        if (m_run >= LOCK_LEN) begin m_mode = 2; m_step = i; end
        else m_mode = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("locked",      a_locked,     int'(m_mode == 2));
    chk("step_valid",  a_step_valid, int'(m_mode == 2));
    chk("step",        a_step,       m_step);
    chk("err",         a_err,        m_err);
    chk("wrap",        a_wrap,       m_wrap);
    chk("err_cnt",     a_err_cnt,    sat(m_errs, 8));
    chk("cycle_cnt",   a_cycle_cnt,  sat(m_cycles, 8));
    chk("s_locked",    b_locked,     int'(m_mode == 2));
    chk("s_step",      b_step,       m_step);
    chk("s_err_cnt",   b_err_cnt,    sat(m_errs, 2));
    chk("s_cycle_cnt", b_cycle_cnt,  sat(m_cycles, 2));
`ifdef SEQ_MONITOR_STICKY_ERR_EN
    chk("err_sticky",  a_sticky,     m_sticky);
    chk("s_err_sticky", b_sticky,    m_sticky);
`endif
  end

  task automatic drive(input bit en, input logic [2:0] q);
    sample_en = en;
    q_in      = q;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear     = 1'b1;
    sample_en = 1'b1;
    q_in      = 3'd4;
    @(posedge clk);
    @(negedge clk);
    #1;
    clear = 1'b0;
    chk("lit_clr_locked", a_locked, 0);
    chk("lit_clr_step", a_step, 0);
    chk("lit_clr_err_cnt", a_err_cnt, 0);
    chk("lit_clr_cycle_cnt", a_cycle_cnt, 0);
    chk("lit_clr_err", a_err, 0);
    chk("lit_clr_wrap", a_wrap, 0);
`ifdef SEQ_MONITOR_STICKY_ERR_EN
    chk("lit_clr_sticky", a_sticky, 0);
`endif
  endtask

  initial begin
    clear = 1'b1; sample_en = 1'b0; q_in = 3'd0;
    do_clear();

    // Lock and wrap
    drive(1, 0); drive(1, 3);
    chk("lit_t1_not_locked", a_locked, 0);
    drive(1, 5);
    chk("lit_t1_locked", a_locked, 1);
    chk("lit_t1_step2", a_step, 2);
    drive(1, 4); drive(1, 7); drive(1, 2);
    chk("lit_t1_step5", a_step, 5);
    drive(1, 0);
    chk("lit_t1_wrap", a_wrap, 1);
    chk("lit_t1_cycle", a_cycle_cnt, 1);
    chk("lit_t1_err_cnt", a_err_cnt, 0);
    drive(1, 3);
    chk("lit_t1_wrap_pulse", a_wrap, 0);

    // Illegal code where 4 is expected
    drive(1, 5); drive(1, 6);
    chk("lit_t2_err", a_err, 1);
    chk("lit_t2_err_cnt", a_err_cnt, 1);
    chk("lit_t2_unlocked", a_locked, 0);
`ifdef SEQ_MONITOR_STICKY_ERR_EN
    chk("lit_t2_sticky", a_sticky, 1);
`endif
    drive(1, 4);
    chk("lit_t2_err_pulse", a_err, 0);
    drive(1, 7); drive(1, 2);
    chk("lit_t2_relock", a_locked, 1);

    // Legal skip, relock on a 0 without wrap
    drive(1, 0); drive(1, 3); drive(1, 5); drive(1, 7);
    chk("lit_t3_err", a_err, 1);
    chk("lit_t3_err_cnt", a_err_cnt, 2);
    drive(1, 2); drive(1, 0);
    chk("lit_t3_relock", a_locked, 1);
    chk("lit_t3_no_wrap", a_wrap, 0);
    chk("lit_t3_cycle", a_cycle_cnt, 2);
    drive(1, 3); drive(1, 5); drive(1, 4); drive(1, 7); drive(1, 2); drive(1, 0);
    chk("lit_t3_wrap", a_wrap, 1);
    chk("lit_t3_cycle3", a_cycle_cnt, 3);

    // Enable gating
    for (int k = 0; k < 5; k++) drive(0, 1);
    chk("lit_t4_locked", a_locked, 1);
    chk("lit_t4_step", a_step, 0);
    chk("lit_t4_err_cnt", a_err_cnt, 2);
    drive(1, 3);
    chk("lit_t4_resume_err", a_err, 0);
    chk("lit_t4_resume_step", a_step, 1);

    // Saturation: five violate/relock rounds
    for (int r = 0; r < 5; r++) begin
      drive(1, 1);
      chk("lit_t5_err", a_err, 1);
      drive(1, 0); drive(1, 3); drive(1, 5);
      chk("lit_t5_relock", a_locked, 1);
    end
    chk("lit_t5_sat", b_err_cnt, 3);
    chk("lit_t5_wide", a_err_cnt, 7);
    drive(1, 5);
    chk("lit_t5_stall_err", a_err, 1);
    chk("lit_t5_sat_hold", b_err_cnt, 3);
    chk("lit_t5_wide8", a_err_cnt, 8);

    // Reset mid-operation
    drive(1, 4); drive(1, 7);
    chk("lit_t6_locked", a_locked, 1);
    do_clear();
    drive(1, 0);
    chk("lit_t6_acq", a_locked, 0);
    drive(1, 3); drive(1, 5);
    chk("lit_t6_lock", a_locked, 1);
    do_clear();
    drive(1, 6);
    chk("lit_t6_hunt_no_err", a_err, 0);
`ifdef SEQ_MONITOR_STICKY_ERR_EN
    chk("lit_t6_hunt_sticky", a_sticky, 1);
`endif
    drive(1, 3); drive(1, 3);
    chk("lit_t6_stall_acq", a_locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
